sirv_uartrx_mv: RTL and testbench

Serial UART receiver; the counterpart of the peripheral UART transmitter. It recovers 8N1 frames (LSB first, one start bit, 8 data bits, one stop bit) from the asynchronous `io_in` line. The bit period is programmed with the same `io_div` value as the transmitter: one bit lasts `io_div+1` clocks. Each received byte is presented as a one-cycle valid pulse to the UART register/FIFO logic, and bad stop bits are flagged as framing errors.

---
 rtl/sirv_uartrx_mv.sv | 136 +++++++++++++
 tb/tb_sirv_uartrx_mv.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sirv_uartrx_mv.sv
// UART 8N1 receiver: samples io_in at mid-bit using a programmable divider and
// emits one-cycle valid / framing-error pulses at the end of each frame.
module sirv_uartrx_mv (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_en,
    input  logic        io_in,
    input  logic [15:0] io_div,
    output logic        io_out_valid,
    output logic [7:0]  io_out_bits,
    output logic        io_err,
    output logic        io_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync0;
    logic        prev;
    logic [15:0] count;
    logic [2:0]  bit_idx;
    logic [7:0]  shifter;
    logic        tick;
    logic        start_cand;
    logic        go_start;
    logic        shift_en;
    logic        good_stop;
    logic        bad_stop;

    assign start_cand = prev & ~sync0;
    assign tick       = (state != IDLE) && (count == 16'd0);
    assign io_busy    = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go_start   = 1'b0;
        shift_en   = 1'b0;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        if (!io_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cand) begin
                        state_next = START;
                        go_start   = 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_next = sync0 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_en = 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_next = IDLE;
                        good_stop  = sync0;
                        bad_stop   = ~sync0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // prev keeps tracking the line while disabled, so a line already low at enable is ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync0 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= io_in;
            sync0 <= sync1;
            prev  <= sync0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= 16'd0;
            bit_idx <= 3'd0;
            shifter <= 8'h00;
        end else begin
            if (go_start) begin
                count <= io_div >> 1;
            end else if (tick) begin
                count <= io_div;
            end else if (state != IDLE) begin
                count <= count - 16'd1;
            end
            if ((state == START) && tick) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shifter <= {sync0, shifter[7:1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_valid <= 1'b0;
            io_err       <= 1'b0;
            io_out_bits  <= 8'h00;
        end else begin
            io_out_valid <= good_stop;
            io_err       <= bad_stop;
            if (good_stop) begin
                io_out_bits <= shifter;
            end
        end
    end

endmodule

// File: tb/tb_sirv_uartrx_mv.sv
// Directed bench for sirv_uartrx_mv: drives 8N1 frames at 16 clocks/bit and
// checks received bytes, pulses, timing window, break, disable and reset.
module tb_sirv_uartrx_mv;

    logic        clock;
    logic        reset;
    logic        io_en;
    logic        io_in;
    logic [15:0] io_div;
    logic        io_out_valid;
    logic [7:0]  io_out_bits;
    logic        io_err;
    logic        io_busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int start_cyc = 0;
    logic [7:0] rx_q[$];
    int         valid_cyc[$];

    sirv_uartrx_mv dut (
        .clock        (clock),
        .reset        (reset),
        .io_en        (io_en),
        .io_in        (io_in),
        .io_div       (io_div),
        .io_out_valid (io_out_valid),
        .io_out_bits  (io_out_bits),
        .io_err       (io_err),
        .io_busy      (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Passive monitor: records every received byte, error pulse and busy cycle
    always @(negedge clock) begin
        if (io_out_valid) begin
            rx_q.push_back(io_out_bits);
            valid_cyc.push_back(cyc);
        end
        if (io_err) err_cnt++;
        if (io_busy) busy_cnt++;
    end

    task automatic clear_monitor();
        rx_q.delete();
        valid_cyc.delete();
        err_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        io_in = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            io_in = b[i];
            repeat (16) @(negedge clock);
        end
        io_in = stop;
        repeat (16) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (io_out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", io_out_valid); else passed++;
        total++; if (io_err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", io_err); else passed++;
        total++; if (io_out_bits !== 8'h00) $display("[TB] FAIL reset_bits got %h want 00", io_out_bits); else passed++;
        total++; if (io_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", io_busy); else passed++;
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_basic();
        int lat;
        clear_monitor();
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clock);
        total++; if (rx_q.size() !== 1) $display("[TB] FAIL basic_count got %0d want 1", rx_q.size()); else passed++;
        total++; if (rx_q.size() < 1 || rx_q[0] !== 8'hA5) $display("[TB] FAIL basic_byte got %h want a5", io_out_bits); else passed++;
        total++; if (err_cnt !== 0) $display("[TB] FAIL basic_err got %0d want 0", err_cnt); else passed++;
        lat = (valid_cyc.size() > 0) ? valid_cyc[0] - start_cyc : -1;
        total++; if (lat < 154 || lat > 157) $display("[TB] FAIL basic_latency got %0d want 154..157", lat); else passed++;
        total++; if (io_busy !== 1'b0) $display("[TB] FAIL basic_idle got %b want 0", io_busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55; exp[3] = 8'h3C;
        clear_monitor();
        for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
        repeat (40) @(negedge clock);
        total++; if (rx_q.size() !== 4) $display("[TB] FAIL b2b_count got %0d want 4", rx_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rx_q.size() <= i || rx_q[i] !== exp[i])
                $display("[TB] FAIL b2b_byte%0d got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp[i]);
            else passed++;
        end
        total++; if (err_cnt !== 0) $display("[TB] FAIL b2b_err got %0d want 0", err_cnt); else passed++;
    endtask

    task automatic test_false_start();
        clear_monitor();
        io_in = 1'b0;
        repeat (3) @(negedge clock);
        io_in = 1'b1;
        repeat (40) @(negedge clock);
        total++; if (busy_cnt < 7 || busy_cnt > 10) $display("[TB] FAIL glitch_busy got %0d want 7..10", busy_cnt); else passed++;
        total++; if (rx_q.size() !== 0) $display("[TB] FAIL glitch_valid got %0d want 0", rx_q.size()); else passed++;
        total++; if (err_cnt !== 0) $display("[TB] FAIL glitch_err got %0d want 0", err_cnt); else passed++;
    endtask

    task automatic test_break();
        clear_monitor();
        send_frame(8'h5A, 1'b0);
        repeat (20) @(negedge clock);
        busy_cnt = 0;
        repeat (40 * 16) @(negedge clock);
        total++; if (err_cnt !== 1) $display("[TB] FAIL break_err got %0d want 1", err_cnt); else passed++;
        total++; if (rx_q.size() !== 0) $display("[TB] FAIL break_valid got %0d want 0", rx_q.size()); else passed++;
        total++; if (io_out_bits !== 8'h3C) $display("[TB] FAIL break_bits got %h want 3c", io_out_bits); else passed++;
        total++; if (busy_cnt !== 0) $display("[TB] FAIL break_retrigger got %0d want 0", busy_cnt); else passed++;
        io_in = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'hC3, 1'b1);
        repeat (20) @(negedge clock);
        total++; if (rx_q.size() !== 1) $display("[TB] FAIL break_recover_count got %0d want 1", rx_q.size()); else passed++;
        total++; if (io_out_bits !== 8'hC3) $display("[TB] FAIL break_recover_bits got %h want c3", io_out_bits); else passed++;
        total++; if (err_cnt !== 1) $display("[TB] FAIL break_recover_err got %0d want 1", err_cnt); else passed++;
    endtask

    task automatic test_disable();
        clear_monitor();
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (72) @(negedge clock);
                io_en = 1'b0;
                @(negedge clock);
                total++; if (io_busy !== 1'b0) $display("[TB] FAIL dis_busy got %b want 0", io_busy); else passed++;
                busy_cnt = 0;
            end
        join
        repeat (20) @(negedge clock);
        total++; if (rx_q.size() !== 0 || err_cnt !== 0) $display("[TB] FAIL dis_pulses got %0d/%0d want 0/0", rx_q.size(), err_cnt); else passed++;
        total++; if (io_out_bits !== 8'hC3) $display("[TB] FAIL dis_bits got %h want c3", io_out_bits); else passed++;
        total++; if (busy_cnt !== 0) $display("[TB] FAIL dis_held_idle got %0d want 0", busy_cnt); else passed++;
        io_en = 1'b1;
        repeat (5) @(negedge clock);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clock);
        total++; if (rx_q.size() !== 1) $display("[TB] FAIL dis_reen_count got %0d want 1", rx_q.size()); else passed++;
        total++; if (io_out_bits !== 8'h81) $display("[TB] FAIL dis_reen_bits got %h want 81", io_out_bits); else passed++;
    endtask

    task automatic test_async_reset();
        fork
            send_frame(8'hE7, 1'b1);
            begin
                repeat (104) @(negedge clock);
                #2 reset = 1'b1;
                #1;
                total++; if (io_out_valid !== 1'b0) $display("[TB] FAIL arst_valid got %b want 0", io_out_valid); else passed++;
                total++; if (io_err !== 1'b0) $display("[TB] FAIL arst_err got %b want 0", io_err); else passed++;
                total++; if (io_out_bits !== 8'h00) $display("[TB] FAIL arst_bits got %h want 00", io_out_bits); else passed++;
                total++; if (io_busy !== 1'b0) $display("[TB] FAIL arst_busy got %b want 0", io_busy); else passed++;
                @(negedge clock);
                reset = 1'b0;
            end
        join
        repeat (200) @(negedge clock);
        clear_monitor();
        send_frame(8'h7E, 1'b1);
        repeat (20) @(negedge clock);
        total++; if (rx_q.size() !== 1) $display("[TB] FAIL arst_next_count got %0d want 1", rx_q.size()); else passed++;
        total++; if (io_out_bits !== 8'h7E) $display("[TB] FAIL arst_next_bits got %h want 7e", io_out_bits); else passed++;
    endtask

    initial begin
        reset  = 1'b1;
        io_en  = 1'b1;
        io_in  = 1'b1;
        io_div = 16'd15;
        @(negedge clock);
        test_reset();
        test_basic();
        test_back_to_back();
        test_false_start();
        test_break();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
